// File: rtl/cu_load_dispatcher.sv
// Load sequencer: takes a load command, issues one burst read, then spreads the returned
// word stream round-robin over the conv-unit weight or kernel buffers.
module cu_load_dispatcher #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned N_CONV_UNIT = 64,
    parameter int unsigned N_KERNEL    = 3,
    parameter int unsigned BURST_WORDS = 16,
    parameter int unsigned B_LEN       = 24,
    parameter int unsigned B_CU        = 6
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_mode,
    input  logic [31:0]                 cmd_addr,
    input  logic [B_LEN-1:0]            cmd_len,
    input  logic [B_CU-1:0]             cmd_cu_first,
    input  logic [1:0]                  cmd_ker_sel,
    input  logic                        pause,
    output logic                        rd_start,
    output logic [31:0]                 rd_addr,
    output logic [31:0]                 rd_nburst,
    input  logic                        rd_idle,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [DATA_WIDTH-1:0]       di,
    output logic [N_CONV_UNIT-1:0]      wb_we,
    output logic [N_CONV_UNIT*N_KERNEL-1:0] kb_we,
    output logic                        busy,
    output logic                        done,
    output logic [B_LEN-1:0]            word_cnt
);

    localparam int unsigned KW      = N_CONV_UNIT * N_KERNEL;
    localparam int unsigned LOG2_BW = $clog2(BURST_WORDS);
    localparam logic [B_LEN-1:0] LEN_MASK = ~B_LEN'(BURST_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_STREAM,
        S_PAUSED,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic                    mode_q, mode_d;
    logic [1:0]              ker_sel_q, ker_sel_d;
    logic [31:0]             rd_addr_q, rd_addr_d;
    logic [31:0]             rd_nburst_q, rd_nburst_d;
    logic [B_LEN-1:0]        len_q, len_d;
    logic [B_CU-1:0]         cu_sel_q, cu_sel_d;
    logic [B_LEN-1:0]        word_cnt_q, word_cnt_d;
    logic [DATA_WIDTH-1:0]   di_q, di_d;
    logic [N_CONV_UNIT-1:0]  wb_we_q, wb_we_d;
    logic [KW-1:0]           kb_we_q, kb_we_d;
    logic                    done_q, done_d;

    logic [B_LEN-1:0]        len_eff;
    logic [31:0]             kidx;
    logic                    beat;

    assign len_eff = cmd_len & LEN_MASK;
    assign kidx    = 32'(cu_sel_q) * N_KERNEL + 32'(ker_sel_q);
    assign beat    = (state_q == S_STREAM) && !pause && s_axis_tvalid;

    assign cmd_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign rd_start      = (state_q == S_REQ) && rd_idle;
    assign s_axis_tready = (state_q == S_STREAM) && !pause;
    assign rd_addr       = rd_addr_q;
    assign rd_nburst     = rd_nburst_q;
    assign di            = di_q;
    assign wb_we         = wb_we_q;
    assign kb_we         = kb_we_q;
    assign done          = done_q;
    assign word_cnt      = word_cnt_q;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        ker_sel_d   = ker_sel_q;
        rd_addr_d   = rd_addr_q;
        rd_nburst_d = rd_nburst_q;
        len_d       = len_q;
        cu_sel_d    = cu_sel_q;
        word_cnt_d  = word_cnt_q;
        di_d        = di_q;
        wb_we_d     = '0;
        kb_we_d     = '0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    mode_d      = cmd_mode;
                    ker_sel_d   = cmd_ker_sel;
                    rd_addr_d   = cmd_addr;
                    rd_nburst_d = 32'(len_eff >> LOG2_BW);
                    len_d       = len_eff;
                    cu_sel_d    = cmd_cu_first;
                    word_cnt_d  = '0;
                    state_d     = (len_eff == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (rd_idle) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (beat) begin
                    di_d = s_axis_tdata;
                    if (mode_q) kb_we_d = KW'(1) << kidx;
                    else        wb_we_d = N_CONV_UNIT'(1) << cu_sel_q;
                    cu_sel_d   = cu_sel_q + 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q + 1'b1 == len_q) state_d = S_DONE;
                end else if (pause) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (!pause) state_d = S_STREAM;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // done is registered alongside the final write enable so both rise together
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            ker_sel_q   <= '0;
            rd_addr_q   <= '0;
            rd_nburst_q <= '0;
            len_q       <= '0;
            cu_sel_q    <= '0;
            word_cnt_q  <= '0;
            di_q        <= '0;
            wb_we_q     <= '0;
            kb_we_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            ker_sel_q   <= ker_sel_d;
            rd_addr_q   <= rd_addr_d;
            rd_nburst_q <= rd_nburst_d;
            len_q       <= len_d;
            cu_sel_q    <= cu_sel_d;
            word_cnt_q  <= word_cnt_d;
            di_q        <= di_d;
            wb_we_q     <= wb_we_d;
            kb_we_q     <= kb_we_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_cu_load_dispatcher.sv
// Scoreboard bench for cu_load_dispatcher: the driver queues expected writes, a negedge
// monitor pops and compares every write-enable pulse it sees.
module tb_cu_load_dispatcher;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_mode = 1'b0;
    logic [31:0]  cmd_addr = '0;
    logic [23:0]  cmd_len = '0;
    logic [5:0]   cmd_cu_first = '0;
    logic [1:0]   cmd_ker_sel = '0;
    logic         pause = 1'b0;
    logic         rd_start;
    logic [31:0]  rd_addr;
    logic [31:0]  rd_nburst;
    logic         rd_idle = 1'b1;
    logic [63:0]  s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic [63:0]  di;
    logic [63:0]  wb_we;
    logic [191:0] kb_we;
    logic         busy;
    logic         done;
    logic [23:0]  word_cnt;

    cu_load_dispatcher #(
        .DATA_WIDTH(64), .N_CONV_UNIT(64), .N_KERNEL(3),
        .BURST_WORDS(16), .B_LEN(24), .B_CU(6)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_cu_first(cmd_cu_first),
        .cmd_ker_sel(cmd_ker_sel), .pause(pause),
        .rd_start(rd_start), .rd_addr(rd_addr), .rd_nburst(rd_nburst), .rd_idle(rd_idle),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .di(di), .wb_we(wb_we), .kb_we(kb_we), .busy(busy), .done(done), .word_cnt(word_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        bit          kern;
        int unsigned idx;
        logic [63:0] data;
    } exp_t;

    exp_t        expq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] rd_addr_seen = '0;
    logic [31:0] rd_nb_seen = '0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] pat(input int tag, input int k);
        return {8'hA5, 8'(tag), 16'h0, 32'(k * 7 + 1)};
    endfunction

    // Monitor: every enable pulse must match the oldest queued expectation.
    exp_t         e;
    logic [191:0] ew, ek;
    always @(negedge aclk) begin
        if (aresetn === 1'b1) begin
            if (rd_start) begin
                rd_cnt++;
                rd_addr_seen = rd_addr;
                rd_nb_seen   = rd_nburst;
            end
            if (done) done_cnt++;
            if (|wb_we || |kb_we) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_we: got wb_we %0h kb_we %0h, required no write", wb_we, kb_we);
                end else begin
                    e  = expq.pop_front();
                    ew = '0;
                    ek = '0;
                    if (e.kern) ek[e.idx] = 1'b1;
                    else        ew[e.idx] = 1'b1;
                    chk("wb_we", 192'(wb_we), ew);
                    chk("kb_we", kb_we, ek);
                    chk("di", 192'(di), 192'(e.data));
                end
            end
        end
    end

    task automatic issue(input bit mode, input logic [31:0] addr, input int len,
                         input int cu, input int ker);
        int guard = 0;
        @(posedge aclk); #1;
        cmd_valid    = 1'b1;
        cmd_mode     = mode;
        cmd_addr     = addr;
        cmd_len      = 24'(len);
        cmd_cu_first = 6'(cu);
        cmd_ker_sel  = 2'(ker);
        @(negedge aclk);
        while (!cmd_ready && guard < 50) begin
            @(negedge aclk);
            guard++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 192'(cmd_ready), 192'(1));
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic stream(input int n, input bit kern, input int cu, input int ker,
                          input int tag, input int pause_at, input bit chk_done, input int len);
        int k = 0;
        int guard = 0;
        bit hs;
        exp_t x;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = pat(tag, 0);
        while (k < n && guard < 300) begin
            @(negedge aclk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge aclk);
            if (hs) begin
                x.kern = kern;
                x.idx  = kern ? (((cu + k) % 64) * 3 + ker) : ((cu + k) % 64);
                x.data = pat(tag, k);
                expq.push_back(x);
                k++;
            end
            #1;
            s_axis_tdata = pat(tag, k);
            guard++;
            if (hs && k == pause_at) begin
                pause = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge aclk);
                    chk("tready_paused", 192'(s_axis_tready), 192'(0));
                    @(posedge aclk); #1;
                end
                chk("word_cnt_paused", 192'(word_cnt), 192'(pause_at));
                pause = 1'b0;
            end
        end
        if (k < n) chk("stream_timeout", 192'(k), 192'(n));
        if (chk_done) begin
            @(negedge aclk);
            chk("done_pulse", 192'(done), 192'(1));
            chk("last_we_with_done", 192'(|wb_we || |kb_we), 192'(1));
            chk("word_cnt_final", 192'(word_cnt), 192'(len));
            @(negedge aclk);
            chk("tready_after_done", 192'(s_axis_tready), 192'(0));
            chk("done_one_cycle", 192'(done), 192'(0));
            s_axis_tvalid = 1'b0;
        end
    endtask

    int r0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_cmd_ready", 192'(cmd_ready), 192'(1));
        chk("rst_busy", 192'(busy), 192'(0));
        chk("rst_done", 192'(done), 192'(0));
        chk("rst_wb_we", 192'(wb_we), 192'(0));
        chk("rst_kb_we", kb_we, 192'(0));
        chk("rst_rd_start", 192'(rd_start), 192'(0));
        chk("rst_tready", 192'(s_axis_tready), 192'(0));
        @(posedge aclk); #1;
        aresetn = 1'b1;

        // 32-word weight load from unit 0
        r0 = rd_cnt;
        issue(1'b0, 32'h0000_1000, 32, 0, 0);
        stream(32, 1'b0, 0, 0, 1, -1, 1'b1, 32);
        chk("rd_start_count", 192'(rd_cnt - r0), 192'(1));
        chk("rd_nburst", 192'(rd_nb_seen), 192'(2));
        chk("rd_addr", 192'(rd_addr_seen), 192'(32'h0000_1000));

        // wrap across the last unit
        issue(1'b0, 32'h0000_2000, 16, 60, 0);
        stream(16, 1'b0, 60, 0, 2, -1, 1'b1, 16);

        // kernel bank 2 from unit 5: bits 17, 20, 23, ...
        issue(1'b1, 32'h0000_3000, 16, 5, 2);
        stream(16, 1'b1, 5, 2, 3, -1, 1'b1, 16);

        // pause for 10 cycles after 8 words
        issue(1'b0, 32'h0000_4000, 16, 10, 0);
        stream(16, 1'b0, 10, 0, 4, 8, 1'b1, 16);

        // read master busy for 20 cycles
        r0 = rd_cnt;
        rd_idle = 1'b0;
        issue(1'b0, 32'h0000_5000, 16, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (rd_start) chk("rd_start_early", 192'(rd_start), 192'(0));
            @(posedge aclk); #1;
        end
        chk("rd_start_held", 192'(rd_cnt - r0), 192'(0));
        rd_idle = 1'b1;
        @(negedge aclk);
        chk("rd_start_on_idle", 192'(rd_start), 192'(1));
        @(posedge aclk); #1;
        stream(16, 1'b0, 0, 0, 5, -1, 1'b1, 16);
        chk("rd_start_once", 192'(rd_cnt - r0), 192'(1));

        // cmd_len below one burst: no read, immediate done
        r0 = rd_cnt;
        issue(1'b0, 32'h0000_6000, 15, 0, 0);
        @(negedge aclk);
        chk("len0_done", 192'(done), 192'(1));
        chk("len0_tready", 192'(s_axis_tready), 192'(0));
        chk("len0_word_cnt", 192'(word_cnt), 192'(0));
        @(negedge aclk);
        chk("len0_idle", 192'(busy), 192'(0));
        chk("len0_no_rd", 192'(rd_cnt - r0), 192'(0));

        // reset in the middle of streaming
        issue(1'b0, 32'h0000_7000, 16, 0, 0);
        stream(5, 1'b0, 0, 0, 7, -1, 1'b0, 16);
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("midrst_cmd_ready", 192'(cmd_ready), 192'(1));
        chk("midrst_busy", 192'(busy), 192'(0));
        chk("midrst_word_cnt", 192'(word_cnt), 192'(0));
        chk("midrst_wb_we", 192'(wb_we), 192'(0));
        chk("midrst_di", 192'(di), 192'(0));
        chk("midrst_rd_nburst", 192'(rd_nburst), 192'(0));
        chk("midrst_tready", 192'(s_axis_tready), 192'(0));
        expq.delete();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        issue(1'b0, 32'h0000_8000, 16, 3, 0);
        stream(16, 1'b0, 3, 0, 8, -1, 1'b1, 16);

        repeat (3) @(negedge aclk);
        chk("scoreboard_empty", 192'(expq.size()), 192'(0));
        chk("done_total", 192'(done_cnt), 192'(7));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
